lcd_scale_feed: RTL and testbench



---
 rtl/lcd_scale_feed_if.sv | 31 +++
 rtl/lcd_scale_feed.sv | 201 ++++++++++++++++++++
 tb/tb_lcd_scale_feed.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_scale_feed_if.sv
// Upstream line-fetch port of lcd_scale_feed.
// master: the scaler. It requests a source line and accepts pixel beats.
// slave : the frame reader. It streams the requested line.
//   fetch_req  - one-cycle pulse that starts streaming line fetch_line
//   fetch_line - source line index, held stable until the line completes
//   src_data   - RGB565 source pixel
//   src_valid  - src_data is valid
//   src_ready  - the scaler accepts a beat (src_valid && src_ready)
interface lcd_scale_feed_if;
    logic        fetch_req;
    logic [10:0] fetch_line;
    logic [15:0] src_data;
    logic        src_valid;
    logic        src_ready;

    modport master (
        output fetch_req,
        output fetch_line,
        output src_ready,
        input  src_data,
        input  src_valid
    );

    modport slave (
        input  fetch_req,
        input  fetch_line,
        input  src_ready,
        output src_data,
        output src_valid
    );
endinterface

// File: rtl/lcd_scale_feed.sv
// Nearest-neighbour upscaler that feeds the RGB LCD timing driver.
// It answers each data_req with an RGB565 pixel one clock later. Source
// lines are pulled on demand into a ping-pong pair of line buffers.
// Ports:
//   lcd_pclk   - pixel clock; the only clock
//   rst_n      - synchronous reset, active low
//   lcd_vs     - field sync from the driver; its rising edge starts a frame
//   data_req   - driver pixel request, DST_W consecutive cycles per line
//   pixel_data - registered RGB565 pixel for the previous cycle's data_req
//   underrun   - sticky; the next display buffer was not ready at a line swap
//   src        - upstream fetch port (lcd_scale_feed_if.master)
//
// Fetch FSM states:
//   state | meaning
//   IDLE  | no fetch in progress; issues a queued or new fetch command
//   REQ   | fetch_req pulse; fetch_line and target buffer are latched
//   LOAD  | src_ready high; beats are written to wr_addr 0..SRC_W-1
module lcd_scale_feed #(
    parameter int SRC_W = 400,
    parameter int SRC_H = 240,
    parameter int DST_W = 800,
    parameter int DST_H = 480
) (
    input  logic             lcd_pclk,
    input  logic             rst_n,
    input  logic             lcd_vs,
    input  logic             data_req,
    output logic [15:0]      pixel_data,
    output logic             underrun,
    lcd_scale_feed_if.master src
);
    localparam int AW = (SRC_W > 1) ? $clog2(SRC_W) : 1;

    typedef enum logic [1:0] {IDLE, REQ, LOAD} fetch_state_t;
    fetch_state_t state, state_nx;

    logic [15:0]   line_buf [2][SRC_W];
    logic [1:0]    buf_valid;
    logic          rd_sel;
    logic          vs_d;
    logic          req_d;
    logic [AW:0]   hx;
    logic [11:0]   hacc;
    logic [10:0]   vacc;
    logic [10:0]   src_y;
    logic [10:0]   fetch_line;
    logic [AW-1:0] wr_addr;
    logic          wr_buf;
    logic          q_valid;
    logic [10:0]   q_line;
    logic          q_buf;

    logic          vs_rise, line_end, v_step, in_frame;
    logic          beat, last_beat, cmd_valid;
    logic [12:0]   hsum;
    logic [11:0]   vsum;
    logic [11:0]   next_fetch;
    logic          go_req, go_buf, q_take;
    logic [10:0]   go_line;
    logic          next_ready;

    assign vs_rise    = lcd_vs & ~vs_d;
    assign line_end   = req_d & ~data_req;
    assign hsum       = {1'b0, hacc} + 13'(SRC_W);
    assign vsum       = {1'b0, vacc} + 12'(SRC_H);
    assign v_step     = line_end && (vsum >= 12'(DST_H));
    // After the step src_y+1 is displayed; beyond the last line there is
    // nothing left to show, so no underrun is reported there.
    assign in_frame   = ({1'b0, src_y} + 12'd1) < 12'(SRC_H);
    assign next_fetch = {1'b0, src_y} + 12'd2;
    assign cmd_valid  = v_step && !vs_rise && (next_fetch < 12'(SRC_H));
    assign beat       = (state == LOAD) && src.src_valid;
    assign last_beat  = beat && (wr_addr == AW'(SRC_W - 1));
    // A line that completes on the swap cycle itself counts as ready.
    assign next_ready = buf_valid[~rd_sel] || (last_beat && (wr_buf != rd_sel));

    assign src.src_ready  = (state == LOAD);
    assign src.fetch_req  = (state == REQ);
    assign src.fetch_line = fetch_line;

    always_comb begin
        state_nx = state;
        go_req   = 1'b0;
        go_line  = q_line;
        go_buf   = q_buf;
        q_take   = 1'b0;
        if (vs_rise) begin
            // Frame start aborts whatever is running and reloads line 0.
            state_nx = REQ;
            go_req   = 1'b1;
            go_line  = '0;
            go_buf   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (q_valid) begin
                        state_nx = REQ;
                        go_req   = 1'b1;
                        q_take   = 1'b1;
                    end else if (cmd_valid) begin
                        state_nx = REQ;
                        go_req   = 1'b1;
                        go_line  = next_fetch[10:0];
                        go_buf   = rd_sel;
                    end
                end
                REQ:     state_nx = LOAD;
                LOAD:    if (last_beat) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge lcd_pclk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge lcd_pclk) begin
        if (rst_n && beat && !vs_rise) line_buf[wr_buf][wr_addr] <= src.src_data;
    end

    always_ff @(posedge lcd_pclk) begin
        if (!rst_n) begin
            vs_d       <= 1'b0;
            req_d      <= 1'b0;
            pixel_data <= '0;
            hx         <= '0;
            hacc       <= '0;
            vacc       <= '0;
            src_y      <= '0;
            rd_sel     <= 1'b0;
            buf_valid  <= '0;
            underrun   <= 1'b0;
            fetch_line <= '0;
            wr_addr    <= '0;
            wr_buf     <= 1'b0;
            q_valid    <= 1'b0;
            q_line     <= '0;
            q_buf      <= 1'b0;
        end else begin
            vs_d  <= lcd_vs;
            req_d <= data_req;

            if (data_req && buf_valid[rd_sel]) pixel_data <= line_buf[rd_sel][hx[AW-1:0]];
            else                               pixel_data <= '0;

            if (!data_req) begin
                hx   <= '0;
                hacc <= '0;
            end else if (hsum >= 13'(DST_W)) begin
                hacc <= 12'(hsum - 13'(DST_W));
                hx   <= hx + (AW+1)'(1);
            end else begin
                hacc <= hsum[11:0];
            end

            // go_req is set on vs_rise, so an aborted final beat never
            // reaches the valid flag.
            if (go_req) begin
                fetch_line <= go_line;
                wr_buf     <= go_buf;
                wr_addr    <= '0;
            end else if (beat) begin
                wr_addr <= last_beat ? '0 : wr_addr + AW'(1);
                if (last_beat) buf_valid[wr_buf] <= 1'b1;
            end

            if (vs_rise) begin
                q_valid <= (SRC_H > 1);
                q_line  <= 11'd1;
                q_buf   <= 1'b1;
            end else begin
                if (q_take) q_valid <= 1'b0;
                if (cmd_valid && !(state == IDLE && !q_valid)) begin
                    q_valid <= 1'b1;
                    q_line  <= next_fetch[10:0];
                    q_buf   <= rd_sel;
                end
            end

            if (vs_rise) begin
                vacc      <= '0;
                src_y     <= '0;
                rd_sel    <= 1'b0;
                buf_valid <= '0;
                underrun  <= 1'b0;
            end else if (line_end) begin
                if (v_step) begin
                    vacc              <= 11'(vsum - 12'(DST_H));
                    src_y             <= src_y + 11'd1;
                    buf_valid[rd_sel] <= 1'b0;
                    rd_sel            <= ~rd_sel;
                    if (!next_ready && in_frame) underrun <= 1'b1;
                end else begin
                    vacc <= vsum[10:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_scale_feed.sv
// Directed bench for lcd_scale_feed at SRC 4x2 -> DST 8x4.
// The upstream model streams pixel = tag + line*16 + x with a selectable
// src_valid pattern. A table of per-line records drives the main checks.
// Hand-written sequences cover reset and a frame-start abort in mid-fetch.
module tb_lcd_scale_feed;
    localparam int SRC_W = 4;
    localparam int SRC_H = 2;
    localparam int DST_W = 8;
    localparam int DST_H = 4;

    logic        lcd_pclk = 1'b0;
    logic        rst_n    = 1'b0;
    logic        lcd_vs   = 1'b0;
    logic        data_req = 1'b0;
    logic [15:0] pixel_data;
    logic        underrun;

    lcd_scale_feed_if src_if ();

    lcd_scale_feed #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .DST_W(DST_W), .DST_H(DST_H)
    ) dut (
        .lcd_pclk  (lcd_pclk),
        .rst_n     (rst_n),
        .lcd_vs    (lcd_vs),
        .data_req  (data_req),
        .pixel_data(pixel_data),
        .underrun  (underrun),
        .src       (src_if)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    int          errors = 0;
    int          checks = 0;
    int          src_mode = 0;
    logic [15:0] tag = 16'h0;
    bit          rand_mode = 1'b1;
    int          ph = 0;
    int          cnt = 0;
    int          beats = 0;
    int          fetch_log[$];

    typedef struct {
        bit          new_frame;
        int          mode;
        logic [15:0] tag;
        logic [15:0] base;
        bit          blank;
        bit          ur;
        int          beats;
    } line_vec_t;

    line_vec_t vec[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Upstream frame reader: mode 0 always valid, mode 1 valid 1,0,0,...,
    // mode 2 never supplies line 1.
    always @(negedge lcd_pclk) begin
        if (rand_mode) begin
            src_if.src_valid = 1'($urandom_range(0, 1));
            src_if.src_data  = 16'($urandom);
        end else begin
            ph++;
            case (src_mode)
                1:       src_if.src_valid = (ph % 3 == 0);
                2:       src_if.src_valid = (src_if.fetch_line != 11'd1);
                default: src_if.src_valid = 1'b1;
            endcase
            src_if.src_data = tag + 16'(src_if.fetch_line) * 16'd16 + 16'(cnt);
        end
    end

    always @(posedge lcd_pclk) begin
        if (rst_n) begin
            if (src_if.fetch_req) begin
                fetch_log.push_back(int'(src_if.fetch_line));
                cnt = 0;
            end
            if (src_if.src_valid && src_if.src_ready) begin
                cnt++;
                beats++;
            end
        end
    end

    task automatic start_frame(input int mode, input logic [15:0] t);
        src_mode = mode;
        tag      = t;
        @(negedge lcd_pclk);
        lcd_vs = 1'b1;
        @(negedge lcd_pclk);
        lcd_vs = 1'b0;
        fetch_log.delete();
        beats = 0;
        check("underrun_clear", underrun, 0);
        repeat (45) @(negedge lcd_pclk);
        check("fetch_count", fetch_log.size(), 2);
        if (fetch_log.size() == 2) begin
            check("fetch_line_first", fetch_log[0], 0);
            check("fetch_line_second", fetch_log[1], 1);
        end
    endtask

    task automatic run_line(input string nm, input logic [15:0] base, input bit blank);
        logic [15:0] exp;
        for (int i = 0; i <= DST_W; i++) begin
            @(negedge lcd_pclk);
            if (i > 0) begin
                exp = blank ? 16'h0 : base + 16'(((i - 1) * SRC_W) / DST_W);
                check($sformatf("%s_x%0d", nm, i - 1), pixel_data, exp);
            end
            data_req = (i < DST_W);
        end
        @(negedge lcd_pclk);
        check({nm, "_idle"}, pixel_data, 0);
        repeat (4) @(negedge lcd_pclk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;

        vec[0]  = '{1'b1, 0, 16'h0000, 16'h0000, 1'b0, 1'b0, -1};
        vec[1]  = '{1'b0, 0, 16'h0000, 16'h0000, 1'b0, 1'b0, -1};
        vec[2]  = '{1'b0, 0, 16'h0000, 16'h0010, 1'b0, 1'b0, -1};
        vec[3]  = '{1'b0, 0, 16'h0000, 16'h0010, 1'b0, 1'b0,  8};
        vec[4]  = '{1'b1, 1, 16'h0200, 16'h0200, 1'b0, 1'b0, -1};
        vec[5]  = '{1'b0, 1, 16'h0200, 16'h0200, 1'b0, 1'b0, -1};
        vec[6]  = '{1'b0, 1, 16'h0200, 16'h0210, 1'b0, 1'b0, -1};
        vec[7]  = '{1'b0, 1, 16'h0200, 16'h0210, 1'b0, 1'b0,  8};
        vec[8]  = '{1'b1, 2, 16'h0500, 16'h0500, 1'b0, 1'b0, -1};
        vec[9]  = '{1'b0, 2, 16'h0500, 16'h0500, 1'b0, 1'b1, -1};
        vec[10] = '{1'b0, 2, 16'h0500, 16'h0000, 1'b1, 1'b1, -1};
        vec[11] = '{1'b0, 2, 16'h0500, 16'h0000, 1'b1, 1'b1,  4};

        // Reset with random inputs.
        for (int i = 0; i < 5; i++) begin
            @(negedge lcd_pclk);
            check("rst_pixel_data", pixel_data, 0);
            check("rst_fetch_req", src_if.fetch_req, 0);
            check("rst_fetch_line", src_if.fetch_line, 0);
            check("rst_src_ready", src_if.src_ready, 0);
            check("rst_underrun", underrun, 0);
            lcd_vs   = 1'($urandom_range(0, 1));
            data_req = 1'($urandom_range(0, 1));
        end
        @(negedge lcd_pclk);
        lcd_vs    = 1'b0;
        data_req  = 1'b0;
        rand_mode = 1'b0;
        rst_n     = 1'b1;
        repeat (3) @(negedge lcd_pclk);

        for (int k = 0; k < 12; k++) begin
            if (vec[k].new_frame) start_frame(vec[k].mode, vec[k].tag);
            run_line($sformatf("pix_v%0d", k), vec[k].base, vec[k].blank);
            check($sformatf("underrun_v%0d", k), underrun, 32'(vec[k].ur));
            if (vec[k].beats >= 0) check($sformatf("beats_v%0d", k), beats, vec[k].beats);
        end

        // Frame start in the middle of a line-0 fetch.
        src_mode = 0;
        tag      = 16'h0A00;
        @(negedge lcd_pclk);
        lcd_vs = 1'b1;
        @(negedge lcd_pclk);
        lcd_vs = 1'b0;
        check("underrun_clear_abort", underrun, 0);
        w = 0;
        while (w < 20 && !(cnt == 2 && src_if.fetch_line == 11'd0 && src_if.src_ready)) begin
            @(negedge lcd_pclk);
            w++;
        end
        checks++;
        if (w >= 20) begin
            errors++;
            $display("FAIL abort_wait: two beats not seen within %0d cycles", w);
        end
        fetch_log.delete();
        tag    = 16'h0B00;
        lcd_vs = 1'b1;
        @(negedge lcd_pclk);
        lcd_vs = 1'b0;
        check("abort_src_ready", src_if.src_ready, 0);
        check("abort_fetch_req", src_if.fetch_req, 1);
        check("abort_fetch_line", src_if.fetch_line, 0);
        repeat (45) @(negedge lcd_pclk);
        check("abort_fetch_count", fetch_log.size(), 2);
        run_line("pix_abort_l1", 16'h0B00, 1'b0);
        run_line("pix_abort_l2", 16'h0B00, 1'b0);
        run_line("pix_abort_l3", 16'h0B10, 1'b0);
        check("abort_underrun", underrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
